ex_mem_stage: RTL and testbench

//  Execute stage plus EX/MEM pipeline register; consumes ID/EX register outputs directly.

---
 rtl/ex_mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, ALU, branch/jump
// resolution, and squashing of wrong-path instructions that follow a redirect.
module ex_mem_stage #(
    parameter int SQUASH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_EX_PC,
    input  logic [31:0] ID_EX_read1_data,
    input  logic [31:0] ID_EX_read2_data,
    input  logic [31:0] ID_EX_imm,
    input  logic [4:0]  ID_EX_RS1,
    input  logic [4:0]  ID_EX_RS2,
    input  logic [4:0]  ID_EX_RD,
    input  logic        ID_EX_RegWrite,
    input  logic [2:0]  ID_EX_WDSel,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_MemWrite,
    input  logic [2:0]  ID_EX_DMType,
    input  logic        ID_EX_ALUSrc,
    input  logic [4:0]  ID_EX_ALUOp,
    input  logic [2:0]  ID_EX_NPCOp,
    input  logic        MEM_WB_RegWrite,
    input  logic [4:0]  MEM_WB_RD,
    input  logic [31:0] MEM_WB_wdata,
    output logic        EX_redirect,
    output logic [31:0] EX_target,
    output logic        EX_MEM_valid,
    output logic [31:0] EX_MEM_PC,
    output logic [31:0] EX_MEM_alu_out,
    output logic [31:0] EX_MEM_store_data,
    output logic [4:0]  EX_MEM_RD,
    output logic        EX_MEM_RegWrite,
    output logic        EX_MEM_MemRead,
    output logic        EX_MEM_MemWrite,
    output logic [2:0]  EX_MEM_WDSel,
    output logic [2:0]  EX_MEM_DMType
);

    typedef enum logic [4:0] {
        OP_B    = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_PCIMM = 5'd3,
        OP_XOR  = 5'd4,  OP_OR   = 5'd5,  OP_AND  = 5'd6,  OP_SLL   = 5'd7,
        OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_SLT  = 5'd10, OP_SLTU  = 5'd11,
        OP_EQ   = 5'd12, OP_NE   = 5'd13, OP_LT   = 5'd14, OP_GE    = 5'd15,
        OP_LTU  = 5'd16, OP_GEU  = 5'd17
    } alu_op_e;

    localparam logic [2:0] NPC_BRANCH = 3'd1;
    localparam logic [2:0] NPC_JAL    = 3'd2;
    localparam logic [2:0] NPC_JALR   = 3'd4;
    localparam logic [2:0] WD_MEM     = 3'd1;
    localparam logic [2:0] WD_PC4     = 3'd2;
    localparam logic [1:0] SQUASH_LOAD = 2'(SQUASH_CYCLES);

    logic        redirect_q,  redirect_d;
    logic [31:0] target_q,    target_d;
    logic        valid_q,     valid_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] alu_out_q,   alu_out_d;
    logic [31:0] store_q,     store_d;
    logic [4:0]  rd_q,        rd_d;
    logic        regwrite_q,  regwrite_d;
    logic        memread_q,   memread_d;
    logic        memwrite_q,  memwrite_d;
    logic [2:0]  wdsel_q,     wdsel_d;
    logic [2:0]  dmtype_q,    dmtype_d;
    logic [1:0]  squash_q,    squash_d;

    logic        ex_fwd_ok;
    logic [31:0] ex_fwd_val;
    logic [31:0] fwd_a, fwd_b;
    logic [31:0] op_a, op_b;
    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic        kill;
    logic        take;

    // A load sitting in EX/MEM has no data yet; ID stalls for that case, so never forward it.
    always_comb begin
        ex_fwd_ok  = valid_q && regwrite_q && (wdsel_q != WD_MEM);
        ex_fwd_val = (wdsel_q == WD_PC4) ? (pc_q + 32'd4) : alu_out_q;
    end

    always_comb begin
        fwd_a = ID_EX_read1_data;
        if (ID_EX_RS1 != 5'd0) begin
            if (ex_fwd_ok && (rd_q == ID_EX_RS1))
                fwd_a = ex_fwd_val;
            else if (MEM_WB_RegWrite && (MEM_WB_RD == ID_EX_RS1))
                fwd_a = MEM_WB_wdata;
        end
    end

    always_comb begin
        fwd_b = ID_EX_read2_data;
        if (ID_EX_RS2 != 5'd0) begin
            if (ex_fwd_ok && (rd_q == ID_EX_RS2))
                fwd_b = ex_fwd_val;
            else if (MEM_WB_RegWrite && (MEM_WB_RD == ID_EX_RS2))
                fwd_b = MEM_WB_wdata;
        end
    end

    assign op_a  = fwd_a;
    assign op_b  = ID_EX_ALUSrc ? ID_EX_imm : fwd_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (ID_EX_ALUOp)
            OP_B:     alu_res = op_b;
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_PCIMM: alu_res = ID_EX_PC + ID_EX_imm;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_SLL:   alu_res = op_a << shamt;
            OP_SRL:   alu_res = op_a >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLT,
            OP_LT:    alu_res = {31'd0, $signed(op_a) <  $signed(op_b)};
            OP_SLTU,
            OP_LTU:   alu_res = {31'd0, op_a <  op_b};
            OP_EQ:    alu_res = {31'd0, op_a == op_b};
            OP_NE:    alu_res = {31'd0, op_a != op_b};
            OP_GE:    alu_res = {31'd0, $signed(op_a) >= $signed(op_b)};
            OP_GEU:   alu_res = {31'd0, op_a >= op_b};
            default:  alu_res = 32'd0;
        endcase
    end

    assign kill = (squash_q != 2'd0);

    always_comb begin
        take     = 1'b0;
        target_d = target_q;
        case (ID_EX_NPCOp)
            NPC_BRANCH: begin
                take     = alu_res[0];
                target_d = ID_EX_PC + ID_EX_imm;
            end
            NPC_JAL: begin
                take     = 1'b1;
                target_d = ID_EX_PC + ID_EX_imm;
            end
            NPC_JALR: begin
                take     = 1'b1;
                target_d = (op_a + ID_EX_imm) & ~32'd1;
            end
            default: begin
                take     = 1'b0;
                target_d = target_q;
            end
        endcase
        if (kill || !take)
            target_d = target_q;
    end

    // Wrong-path instructions still latch their fields but lose every side effect.
    always_comb begin
        redirect_d = take && !kill;
        valid_d    = !kill;
        pc_d       = ID_EX_PC;
        alu_out_d  = alu_res;
        store_d    = fwd_b;
        rd_d       = ID_EX_RD;
        regwrite_d = ID_EX_RegWrite && !kill;
        memread_d  = ID_EX_MemRead  && !kill;
        memwrite_d = ID_EX_MemWrite && !kill;
        wdsel_d    = ID_EX_WDSel;
        dmtype_d   = ID_EX_DMType;
        if (redirect_d)
            squash_d = SQUASH_LOAD;
        else if (kill)
            squash_d = squash_q - 2'd1;
        else
            squash_d = squash_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_q <= 1'b0;
            target_q   <= 32'd0;
            valid_q    <= 1'b0;
            pc_q       <= 32'd0;
            alu_out_q  <= 32'd0;
            store_q    <= 32'd0;
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            wdsel_q    <= 3'd0;
            dmtype_q   <= 3'd0;
            squash_q   <= 2'd0;
        end else begin
            redirect_q <= redirect_d;
            target_q   <= target_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            alu_out_q  <= alu_out_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            wdsel_q    <= wdsel_d;
            dmtype_q   <= dmtype_d;
            squash_q   <= squash_d;
        end
    end

    assign EX_redirect       = redirect_q;
    assign EX_target         = target_q;
    assign EX_MEM_valid      = valid_q;
    assign EX_MEM_PC         = pc_q;
    assign EX_MEM_alu_out    = alu_out_q;
    assign EX_MEM_store_data = store_q;
    assign EX_MEM_RD         = rd_q;
    assign EX_MEM_RegWrite   = regwrite_q;
    assign EX_MEM_MemRead    = memread_q;
    assign EX_MEM_MemWrite   = memwrite_q;
    assign EX_MEM_WDSel      = wdsel_q;
    assign EX_MEM_DMType     = dmtype_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: forwarding, ALU ops, branches/jumps, squash and reset.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ID_EX_PC, ID_EX_read1_data, ID_EX_read2_data, ID_EX_imm;
    logic [4:0]  ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc;
    logic [2:0]  ID_EX_WDSel, ID_EX_DMType, ID_EX_NPCOp;
    logic [4:0]  ID_EX_ALUOp;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_RD;
    logic [31:0] MEM_WB_wdata;
    logic        EX_redirect, EX_MEM_valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
    logic [31:0] EX_target, EX_MEM_PC, EX_MEM_alu_out, EX_MEM_store_data;
    logic [4:0]  EX_MEM_RD;
    logic [2:0]  EX_MEM_WDSel, EX_MEM_DMType;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(.SQUASH_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_PC(ID_EX_PC), .ID_EX_read1_data(ID_EX_read1_data),
        .ID_EX_read2_data(ID_EX_read2_data), .ID_EX_imm(ID_EX_imm),
        .ID_EX_RS1(ID_EX_RS1), .ID_EX_RS2(ID_EX_RS2), .ID_EX_RD(ID_EX_RD),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_WDSel(ID_EX_WDSel),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
        .ID_EX_DMType(ID_EX_DMType), .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_NPCOp(ID_EX_NPCOp),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_RD(MEM_WB_RD),
        .MEM_WB_wdata(MEM_WB_wdata),
        .EX_redirect(EX_redirect), .EX_target(EX_target),
        .EX_MEM_valid(EX_MEM_valid), .EX_MEM_PC(EX_MEM_PC),
        .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_store_data(EX_MEM_store_data),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_WDSel(EX_MEM_WDSel), .EX_MEM_DMType(EX_MEM_DMType)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clr();
        ID_EX_PC = 32'd0; ID_EX_read1_data = 32'd0; ID_EX_read2_data = 32'd0;
        ID_EX_imm = 32'd0; ID_EX_RS1 = 5'd0; ID_EX_RS2 = 5'd0; ID_EX_RD = 5'd0;
        ID_EX_RegWrite = 1'b0; ID_EX_WDSel = 3'd0; ID_EX_MemRead = 1'b0;
        ID_EX_MemWrite = 1'b0; ID_EX_DMType = 3'd0; ID_EX_ALUSrc = 1'b0;
        ID_EX_ALUOp = 5'd0; ID_EX_NPCOp = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        clr();
        ID_EX_read1_data = a;
        ID_EX_read2_data = b;
        ID_EX_ALUOp = op;
        step();
        check(tag, EX_MEM_alu_out, exp);
    endtask

    function automatic logic [31:0] out_bits();
        return {EX_redirect, EX_MEM_valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite,
                EX_MEM_WDSel, EX_MEM_DMType, EX_MEM_RD}
               | EX_target | EX_MEM_PC | EX_MEM_alu_out | EX_MEM_store_data;
    endfunction

    initial begin
        clr();
        MEM_WB_RegWrite = 1'b0; MEM_WB_RD = 5'd0; MEM_WB_wdata = 32'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", out_bits(), 32'd0);
        @(negedge clk) rst = 1'b1;

        // add x1 = 5 + 7
        clr();
        ID_EX_PC = 32'h10; ID_EX_read1_data = 32'd5; ID_EX_read2_data = 32'd7;
        ID_EX_RS1 = 5'd10; ID_EX_RS2 = 5'd11; ID_EX_RD = 5'd1;
        ID_EX_RegWrite = 1'b1; ID_EX_ALUOp = 5'd1;
        step();
        check("add_alu", EX_MEM_alu_out, 32'd12);
        check("add_valid", {31'd0, EX_MEM_valid}, 32'd1);
        check("add_rd", {27'd0, EX_MEM_RD}, 32'd1);
        check("add_pc", EX_MEM_PC, 32'h10);
        check("add_store", EX_MEM_store_data, 32'd7);

        // add x2 = x1 + x1 via EX/MEM forward
        clr();
        ID_EX_RS1 = 5'd1; ID_EX_RS2 = 5'd1; ID_EX_RD = 5'd2;
        ID_EX_RegWrite = 1'b1; ID_EX_ALUOp = 5'd1;
        step();
        check("fwd_exmem_alu", EX_MEM_alu_out, 32'd24);
        check("fwd_exmem_store", EX_MEM_store_data, 32'd12);

        // x1 = 9, then read x1 while MEM/WB also holds x1 = 3
        clr();
        ID_EX_ALUSrc = 1'b1; ID_EX_imm = 32'd9; ID_EX_RD = 5'd1; ID_EX_RegWrite = 1'b1;
        step();
        check("li_x1", EX_MEM_alu_out, 32'd9);
        clr();
        MEM_WB_RegWrite = 1'b1; MEM_WB_RD = 5'd1; MEM_WB_wdata = 32'd3;
        ID_EX_RS1 = 5'd1; ID_EX_ALUOp = 5'd1; ID_EX_RD = 5'd3; ID_EX_RegWrite = 1'b1;
        step();
        check("fwd_priority", EX_MEM_alu_out, 32'd9);
        clr();
        ID_EX_RS1 = 5'd1; ID_EX_RS2 = 5'd5; ID_EX_read2_data = 32'd100;
        ID_EX_ALUOp = 5'd1; ID_EX_RD = 5'd3; ID_EX_RegWrite = 1'b1;
        step();
        check("fwd_memwb", EX_MEM_alu_out, 32'd103);
        MEM_WB_RegWrite = 1'b0;

        alu_case("alu_sub",   5'd2,  32'd5, 32'd7, 32'hFFFF_FFFE);
        alu_case("alu_xor",   5'd4,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
        alu_case("alu_sll",   5'd7,  32'd1, 32'd33, 32'd2);
        alu_case("alu_srl",   5'd8,  32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_case("alu_sra",   5'd9,  32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_case("alu_slt",   5'd10, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_case("alu_sltu",  5'd11, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_case("alu_geu",   5'd17, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_case("alu_undef", 5'd20, 32'd5, 32'd7, 32'd0);
        clr();
        ID_EX_PC = 32'h40; ID_EX_imm = 32'h10; ID_EX_ALUOp = 5'd3;
        step();
        check("alu_pcimm", EX_MEM_alu_out, 32'h50);

        // write to x0, then read x0: no forwarding from either stage
        clr();
        ID_EX_ALUSrc = 1'b1; ID_EX_imm = 32'd77; ID_EX_RD = 5'd0; ID_EX_RegWrite = 1'b1;
        step();
        clr();
        MEM_WB_RegWrite = 1'b1; MEM_WB_RD = 5'd0; MEM_WB_wdata = 32'd55;
        ID_EX_ALUSrc = 1'b1; ID_EX_imm = 32'd5; ID_EX_ALUOp = 5'd1;
        step();
        check("x0_no_fwd", EX_MEM_alu_out, 32'd5);
        MEM_WB_RegWrite = 1'b0;

        // load x4, then dependent use: EX/MEM forward suppressed
        clr();
        ID_EX_PC = 32'h20; ID_EX_read1_data = 32'h1000; ID_EX_imm = 32'd8;
        ID_EX_ALUSrc = 1'b1; ID_EX_ALUOp = 5'd1; ID_EX_RD = 5'd4; ID_EX_RegWrite = 1'b1;
        ID_EX_WDSel = 3'd1; ID_EX_MemRead = 1'b1; ID_EX_DMType = 3'd2;
        step();
        check("load_addr", EX_MEM_alu_out, 32'h1008);
        check("load_memread", {31'd0, EX_MEM_MemRead}, 32'd1);
        check("load_dmtype", {29'd0, EX_MEM_DMType}, 32'd2);
        clr();
        MEM_WB_RegWrite = 1'b1; MEM_WB_RD = 5'd4; MEM_WB_wdata = 32'hAA;
        ID_EX_RS1 = 5'd4; ID_EX_read1_data = 32'h11; ID_EX_ALUOp = 5'd1;
        ID_EX_RD = 5'd6; ID_EX_RegWrite = 1'b1;
        step();
        check("load_use_memwb", EX_MEM_alu_out, 32'hAA);
        MEM_WB_RegWrite = 1'b0;

        // beq x0,x0,+16 at 0x100
        clr();
        ID_EX_PC = 32'h100; ID_EX_imm = 32'd16; ID_EX_ALUOp = 5'd12; ID_EX_NPCOp = 3'd1;
        step();
        check("beq_redirect", {31'd0, EX_redirect}, 32'd1);
        check("beq_target", EX_target, 32'h110);
        clr();
        ID_EX_PC = 32'h104; ID_EX_RD = 5'd7; ID_EX_RegWrite = 1'b1;
        ID_EX_MemWrite = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_ALUOp = 5'd1;
        step();
        check("kill_valid", {31'd0, EX_MEM_valid}, 32'd0);
        check("kill_writes", {29'd0, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite}, 32'd0);
        check("redirect_one_cycle", {31'd0, EX_redirect}, 32'd0);
        clr();
        ID_EX_PC = 32'h108; ID_EX_read1_data = 32'd1; ID_EX_read2_data = 32'd2;
        ID_EX_ALUOp = 5'd1; ID_EX_RD = 5'd8; ID_EX_RegWrite = 1'b1;
        step();
        check("after_kill_valid", {31'd0, EX_MEM_valid}, 32'd1);
        check("after_kill_alu", EX_MEM_alu_out, 32'd3);

        // bne x0,x0: not taken, target holds
        clr();
        ID_EX_PC = 32'h200; ID_EX_imm = 32'd16; ID_EX_ALUOp = 5'd13; ID_EX_NPCOp = 3'd1;
        step();
        check("bne_no_redirect", {31'd0, EX_redirect}, 32'd0);
        check("bne_target_hold", EX_target, 32'h110);

        // JALR rs1=0x203 imm=0, then a back-to-back JAL on the wrong path
        clr();
        ID_EX_PC = 32'h300; ID_EX_RS1 = 5'd9; ID_EX_read1_data = 32'h203;
        ID_EX_NPCOp = 3'd4; ID_EX_RD = 5'd1; ID_EX_RegWrite = 1'b1; ID_EX_WDSel = 3'd2;
        step();
        check("jalr_redirect", {31'd0, EX_redirect}, 32'd1);
        check("jalr_target", EX_target, 32'h202);
        clr();
        ID_EX_PC = 32'h304; ID_EX_imm = 32'h40; ID_EX_NPCOp = 3'd2;
        ID_EX_RD = 5'd1; ID_EX_RegWrite = 1'b1; ID_EX_WDSel = 3'd2;
        step();
        check("jal_b2b_killed", {30'd0, EX_redirect, EX_MEM_valid}, 32'd0);
        check("jal_b2b_target", EX_target, 32'h202);
        clr();
        ID_EX_PC = 32'h400; ID_EX_imm = 32'h20; ID_EX_NPCOp = 3'd2;
        step();
        check("jal_redirect", {31'd0, EX_redirect}, 32'd1);
        check("jal_target", EX_target, 32'h420);

        // reset while a squash and redirect are pending
        #2 rst = 1'b0;
        #1;
        check("reset_mid_squash", out_bits(), 32'd0);
        @(negedge clk) rst = 1'b1;
        clr();
        ID_EX_PC = 32'h500; ID_EX_read1_data = 32'd2; ID_EX_read2_data = 32'd3;
        ID_EX_ALUOp = 5'd1;
        step();
        check("post_reset_valid", {31'd0, EX_MEM_valid}, 32'd1);
        check("post_reset_alu", EX_MEM_alu_out, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
